// File: rtl/mix_state_drain.sv
// mix_state_drain: captures one WORDS x W state snapshot per input handshake,
// streams it out one word per beat, and keeps a rotate-xor digest plus a
// completed-frame counter so long runs can be checked from a single word.
module mix_state_drain #(
  parameter int WORDS = 8,
  parameter int W     = 32,
  parameter int CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WORDS*W-1:0]         in_data,
  input  logic                       clear,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [W-1:0]               out_data,
  output logic [$clog2(WORDS)-1:0]   out_index,
  output logic                       out_last,
  output logic [W-1:0]               digest,
  output logic [CNT_W-1:0]           frame_count
);

  localparam int IDX_W = $clog2(WORDS);
  localparam int ROT   = 5 % W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t             state_r;
  logic [IDX_W-1:0]   idx_r;
  logic [W-1:0]       buf_r [WORDS];
  logic               out_valid_r;
  logic [W-1:0]       out_data_r;
  logic               out_last_r;
  logic [W-1:0]       digest_r;
  logic [CNT_W-1:0]   frame_count_r;

  logic               beat_s;
  logic               last_beat_s;
  logic               in_ready_s;
  logic               capture_s;
  logic [IDX_W-1:0]   next_idx_s;

  // Rotate left by ROT bits, modulo W (ROT of zero returns the input).
  function automatic logic [W-1:0] rotl(input logic [W-1:0] v);
    logic [2*W-1:0] tmp;
    tmp  = {v, v} << ROT;
    rotl = tmp[2*W-1:W];
  endfunction

  // Handshake decode: a beat moves one word out; capture is allowed in IDLE
  // or on the final beat of a frame so back-to-back frames have no bubble.
  always_comb begin
    beat_s      = out_valid_r & out_ready;
    last_beat_s = beat_s & out_last_r;
    next_idx_s  = idx_r + IDX_W'(1);
    if (state_r == IDLE) begin
      in_ready_s = 1'b1;
    end else begin
      in_ready_s = out_last_r & out_ready;
    end
    capture_s = in_valid & in_ready_s;
  end

  // Shadow buffer: loads the whole snapshot on each accepted capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < WORDS; i++) begin
        buf_r[i] <= '0;
      end
    end else if (capture_s) begin
      for (int i = 0; i < WORDS; i++) begin
        buf_r[i] <= in_data[i*W +: W];
      end
    end else begin
      for (int i = 0; i < WORDS; i++) begin
        buf_r[i] <= buf_r[i];
      end
    end
  end

  // Drain FSM with registered word outputs; the next word is preselected so
  // outputs hold steady while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      idx_r       <= '0;
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      out_last_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (capture_s) begin
            state_r     <= DRAIN;
            idx_r       <= '0;
            out_valid_r <= 1'b1;
            out_data_r  <= in_data[W-1:0];
            out_last_r  <= 1'b0;
          end
        end
        DRAIN: begin
          if (beat_s) begin
            if (out_last_r) begin
              if (capture_s) begin
                idx_r       <= '0;
                out_data_r  <= in_data[W-1:0];
                out_last_r  <= 1'b0;
              end else begin
                state_r     <= IDLE;
                idx_r       <= '0;
                out_valid_r <= 1'b0;
                out_data_r  <= '0;
                out_last_r  <= 1'b0;
              end
            end else begin
              idx_r      <= next_idx_s;
              out_data_r <= buf_r[next_idx_s];
              out_last_r <= (next_idx_s == LAST_IDX);
            end
          end
        end
        default: begin
          state_r     <= IDLE;
          idx_r       <= '0;
          out_valid_r <= 1'b0;
          out_data_r  <= '0;
          out_last_r  <= 1'b0;
        end
      endcase
    end
  end

  // Digest and frame counter; clear wins over any same-cycle beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digest_r      <= '0;
      frame_count_r <= '0;
    end else if (clear) begin
      digest_r      <= '0;
      frame_count_r <= '0;
    end else if (beat_s) begin
      digest_r <= rotl(digest_r) ^ out_data_r;
      if (last_beat_s) begin
        frame_count_r <= frame_count_r + CNT_W'(1);
      end else begin
        frame_count_r <= frame_count_r;
      end
    end else begin
      digest_r      <= digest_r;
      frame_count_r <= frame_count_r;
    end
  end

  assign in_ready    = in_ready_s;
  assign out_valid   = out_valid_r;
  assign out_data    = out_data_r;
  assign out_index   = idx_r;
  assign out_last    = out_last_r;
  assign digest      = digest_r;
  assign frame_count = frame_count_r;

endmodule

// File: tb/tb_mix_state_drain.sv
// Self-checking bench for mix_state_drain. A negedge monitor keeps a
// scoreboard of expected words (pushed at capture, popped per beat) plus a
// reference digest/counter; scenario tasks add their own targeted checks.
module tb_mix_state_drain;

  localparam int WORDS = 8;
  localparam int W     = 32;
  // Narrow counter so the wrap point is reachable in a short run.
  localparam int CNT_W = 4;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [WORDS*W-1:0] in_data = '0;
  logic               clear = 1'b0;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic [W-1:0]       out_data;
  logic [2:0]         out_index;
  logic               out_last;
  logic [W-1:0]       digest;
  logic [CNT_W-1:0]   frame_count;

  int tests_run = 0;
  int tests_failed = 0;

  logic [W-1:0]     exp_q[$];
  logic [W-1:0]     md = '0;
  logic [CNT_W-1:0] mc = '0;
  logic             m_ready;
  logic [W-1:0]     m_word;
  logic [2:0]       m_idx;
  logic             m_beat;

  mix_state_drain #(.WORDS(WORDS), .W(W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .clear(clear), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_index(out_index),
    .out_last(out_last), .digest(digest), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] ref_rotl5(input logic [W-1:0] v);
    return (v << 5) | (v >> (W - 5));
  endfunction

  // Scoreboard monitor: compare against the reference model, then advance it.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      md = '0;
      mc = '0;
    end else begin
      m_ready = (exp_q.size() == 0) || (exp_q.size() == 1 && out_ready);
      tests_run++;
      if (out_valid !== (exp_q.size() != 0)) begin
        tests_failed++;
        $display("FAIL sb_valid got %b exp %b", out_valid, exp_q.size() != 0);
      end
      tests_run++;
      if (in_ready !== m_ready) begin
        tests_failed++;
        $display("FAIL sb_in_ready got %b exp %b", in_ready, m_ready);
      end
      if (exp_q.size() != 0) begin
        m_idx = 3'(WORDS - exp_q.size());
        tests_run++;
        if (out_data !== exp_q[0]) begin
          tests_failed++;
          $display("FAIL sb_data got %h exp %h", out_data, exp_q[0]);
        end
        tests_run++;
        if (out_index !== m_idx) begin
          tests_failed++;
          $display("FAIL sb_index got %0d exp %0d", out_index, m_idx);
        end
        tests_run++;
        if (out_last !== (m_idx == 3'd7)) begin
          tests_failed++;
          $display("FAIL sb_last got %b exp %b", out_last, m_idx == 3'd7);
        end
      end
      tests_run++;
      if (digest !== md) begin
        tests_failed++;
        $display("FAIL sb_digest got %h exp %h", digest, md);
      end
      tests_run++;
      if (frame_count !== mc) begin
        tests_failed++;
        $display("FAIL sb_frame_count got %0d exp %0d", frame_count, mc);
      end
      // Advance the model to the state after the coming posedge.
      m_beat = (exp_q.size() != 0) && out_ready;
      if (m_beat) begin
        m_word = exp_q.pop_front();
        if (clear) begin
          md = '0;
          mc = '0;
        end else begin
          md = ref_rotl5(md) ^ m_word;
          if (exp_q.size() == 0) mc = mc + 4'd1;
        end
      end else if (clear) begin
        md = '0;
        mc = '0;
      end
      if (in_valid && m_ready) begin
        for (int i = 0; i < WORDS; i++) exp_q.push_back(in_data[i*W +: W]);
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic set_frame(input logic [W-1:0] base, input logic [W-1:0] stride);
    for (int i = 0; i < WORDS; i++) in_data[i*W +: W] = base + stride * i;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    in_valid = 1'b0;
    clear = 1'b0;
    out_ready = 1'b0;
    tick;
    tick;
    rst_n = 1'b1;
  endtask

  task automatic send_frame(input logic [W-1:0] base);
    set_frame(base, 32'd1);
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    repeat (8) tick;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (out_valid !== 1'b0 || out_data !== 32'd0 || out_index !== 3'd0 || out_last !== 1'b0 ||
        digest !== 32'd0 || frame_count !== 4'd0 || in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_state got v=%b d=%h i=%0d l=%b g=%h c=%0d r=%b exp all 0 and in_ready 1",
               out_valid, out_data, out_index, out_last, digest, frame_count, in_ready);
    end
    do_reset;
  endtask

  task automatic test_basic;
    do_reset;
    set_frame(32'd0, 32'd1);
    out_ready = 1'b1;
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    tests_run++;
    if (out_valid !== 1'b1 || out_data !== 32'd0) begin
      tests_failed++;
      $display("FAIL basic_first got v=%b d=%h exp v=1 d=0", out_valid, out_data);
    end
    repeat (8) tick;
    tests_run++;
    if (digest !== 32'h443214C7 || frame_count !== 4'd1 || out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_end got g=%h c=%0d v=%b exp g=443214c7 c=1 v=0", digest, frame_count, out_valid);
    end
  endtask

  task automatic test_backpressure;
    int beats;
    beats = 0;
    do_reset;
    set_frame(32'd0, 32'd1);
    out_ready = 1'b1;
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    for (int k = 0; k < 100 && out_valid; k++) begin
      out_ready = (k % 3 == 0);
      if (out_valid && out_ready) beats++;
      tick;
    end
    out_ready = 1'b1;
    tests_run++;
    if (beats != 8 || out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_beats got %0d v=%b exp 8 v=0", beats, out_valid);
    end
    tests_run++;
    if (digest !== 32'h443214C7 || frame_count !== 4'd1) begin
      tests_failed++;
      $display("FAIL bp_digest got g=%h c=%0d exp g=443214c7 c=1", digest, frame_count);
    end
  endtask

  task automatic test_back_to_back;
    do_reset;
    set_frame(32'h1, 32'd0);
    out_ready = 1'b1;
    in_valid = 1'b1;
    tick;
    set_frame(32'h2, 32'd0);
    repeat (7) tick;
    tests_run++;
    if (in_ready !== 1'b1 || out_last !== 1'b1) begin
      tests_failed++;
      $display("FAIL b2b_ready got r=%b l=%b exp r=1 l=1", in_ready, out_last);
    end
    tick;
    in_valid = 1'b0;
    tests_run++;
    if (out_valid !== 1'b1 || out_index !== 3'd0 || out_data !== 32'h2) begin
      tests_failed++;
      $display("FAIL b2b_no_bubble got v=%b i=%0d d=%h exp v=1 i=0 d=2", out_valid, out_index, out_data);
    end
    repeat (8) tick;
    tests_run++;
    if (frame_count !== 4'd2 || out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_count got c=%0d v=%b exp c=2 v=0", frame_count, out_valid);
    end
  endtask

  task automatic test_reset_mid_drain;
    do_reset;
    set_frame(32'd0, 32'd1);
    out_ready = 1'b1;
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    repeat (4) tick;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (out_valid !== 1'b0 || out_data !== 32'd0 || out_index !== 3'd0 || out_last !== 1'b0 ||
        digest !== 32'd0 || frame_count !== 4'd0 || in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL mid_reset got v=%b d=%h i=%0d l=%b g=%h c=%0d r=%b exp all 0 and in_ready 1",
               out_valid, out_data, out_index, out_last, digest, frame_count, in_ready);
    end
    tick;
    tick;
    rst_n = 1'b1;
    send_frame(32'd0);
    tests_run++;
    if (digest !== 32'h443214C7 || frame_count !== 4'd1) begin
      tests_failed++;
      $display("FAIL mid_reset_after got g=%h c=%0d exp g=443214c7 c=1", digest, frame_count);
    end
  endtask

  task automatic test_wrap;
    do_reset;
    out_ready = 1'b1;
    for (int f = 0; f < 15; f++) send_frame(32'(f * 16));
    tests_run++;
    if (frame_count !== 4'hF) begin
      tests_failed++;
      $display("FAIL wrap_pre got %0d exp 15", frame_count);
    end
    send_frame(32'h55);
    tests_run++;
    if (frame_count !== 4'd0) begin
      tests_failed++;
      $display("FAIL wrap_post got %0d exp 0", frame_count);
    end
  endtask

  task automatic test_clear;
    do_reset;
    out_ready = 1'b1;
    send_frame(32'h100);
    set_frame(32'd0, 32'd1);
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    repeat (7) tick;
    clear = 1'b1;
    tick;
    clear = 1'b0;
    tests_run++;
    if (digest !== 32'd0 || frame_count !== 4'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL clear_last got g=%h c=%0d v=%b r=%b exp g=0 c=0 v=0 r=1",
               digest, frame_count, out_valid, in_ready);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_backpressure;
    test_back_to_back;
    test_reset_mid_drain;
    test_wrap;
    test_clear;
    tick;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
